ddr3_cache_arbiter: RTL
=======================

# ddr3_cache_arbiter

Three-port round-robin arbiter that shares the single request/ack port of the DDR3 line cache between requesters: instruction fetch (m0), data access (m1) and the framebuffer/DMA reader (m2). It sits between the requesters and the cache. It serialises whole 256-bit line transactions. Each transaction is latched into registered cache-side outputs, held until the cache acknowledges, then completed toward the granted requester with a one-cycle ack and the captured read data.

## Interface
Parameters:
- none. The port count is fixed at 3 and the line width at 256 bits.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_addr_i  in  32  byte address for requester N (N = 0, 1, 2).
- mN_data_i  in  256  write line for requester N.
- mN_rd_i  in  1  read request from requester N; level, held until mN_ack_o.
- mN_we_i  in  1  write request from requester N; level, held until mN_ack_o.
- mN_ack_o  out  1  one-cycle completion pulse to requester N.
- mN_data_o  out  256  read line; all three are driven from one shared register and are valid while mN_ack_o is high.
- c_addr_o  out  32  address to the cache.
- c_data_o  out  256  write line to the cache.
- c_rd_o  out  1  read request to the cache.
- c_we_o  out  1  write request to the cache.
- c_data_i  in  256  read line from the cache; valid while c_ack_i is high.
- c_ack_i  in  1  cache completion pulse.
- grant_o  out  2  index of the requester currently owning the cache; 3 means none.
- busy_o  out  1  high while state is not IDLE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - Requester N is pending when mN_rd_i or mN_we_i is high.
  - Search order is ptr, ptr+1, ptr+2 (mod 3). The first pending requester g wins.
  - On a win, latch c_addr_o <= mg_addr_i and c_data_o <= mg_data_i.
  - If mg_we_i is high, set c_we_o <= 1. Otherwise set c_rd_o <= 1.
  - Also set grant_o <= g and go to BUSY.
  - With nothing pending, stay in IDLE with all outputs unchanged.
- Both rd and we high on one requester: treated as a write; c_rd_o stays 0. c_rd_o and c_we_o are never high together.
- BUSY:
  - Hold c_addr_o, c_data_o, c_rd_o and c_we_o stable until c_ack_i.
  - On c_ack_i: c_rd_o <= 0, c_we_o <= 0, rdata <= c_data_i (captured for writes too), ptr <= (g+1) mod 3, go to DONE.
  - Requester inputs are ignored in BUSY. Changes to a granted requester's inputs are not forwarded.
- DONE:
  - mg_ack_o = 1 for exactly this cycle.
  - On the next edge: grant_o <= 3 and go to IDLE.
- Requesters drop their request on the edge at which they sample ack. IDLE therefore never re-grants the finished transaction.
- Fairness: a continuously pending requester is granted within 3 transactions. No requester is granted twice in a row while another is pending.
- mN_ack_o = (state == DONE) && (grant_o == N). The ack is a decode of registered state, with no combinational path from any input.
- c_ack_i seen in IDLE or DONE: ignored.
- Reset:
  - Takes effect at any state, including mid-transaction; the cache shares rst and aborts as well.
  - Reset values: state IDLE, ptr 0, grant_o 3, busy_o 0.
  - c_addr_o 0, c_data_o 0, c_rd_o 0, c_we_o 0.
  - All mN_ack_o 0, rdata (all mN_data_o) 0.

## Timing
- Cycle 0: request first seen high in IDLE.
- Cycle 1: c_rd_o or c_we_o high, busy_o high.
- Cycle k: c_ack_i high.
- Cycle k+1: mN_ack_o high with mN_data_o valid.
- Cycle k+2: IDLE; a new grant is registered in that cycle.
- With a 2-cycle cache hit (k = 2): request to ack is 3 cycles, and back-to-back transactions from different requesters run every 4 cycles.
- Cache misses extend BUSY with no upper bound. There is no timeout.

## Test plan
- Single read:
  - m1 reads 0x0000_1040; cache acks at cycle 2 with data 0xA5..A5.
  - Required: c_rd_o = 1 in cycles 1–2, c_addr_o = 0x0000_1040, m1_ack_o = 1 only at cycle 3 with m1_data_o = 0xA5..A5, grant_o = 1 during cycles 1–3.
- Simultaneous requests after reset (ptr 0):
  - m0, m1 and m2 all request continuously.
  - Required grant order: 0, 1, 2, 0. Exactly one ack per transaction, to the granted requester only.
- Write plus read on one requester:
  - m2 drives both we and rd with data 0x1234.
  - Required: c_we_o = 1, c_rd_o = 0, c_data_o = 0x1234.
- Slow cache:
  - c_ack_i delayed by 50 cycles while m0 changes its addr and data mid-transaction.
  - Required: c_addr_o and c_data_o stay at the values latched in IDLE; m0_ack_o is asserted 1 cycle after c_ack_i.
- Reset mid-transaction:
  - rst asserted in BUSY.
  - Required next cycle: c_rd_o = c_we_o = 0, grant_o = 3, busy_o = 0, all acks 0.
  - After release, a new m2 request is granted as if ptr = 0; with m0 and m2 both pending, m0 is granted first.
- Spurious ack:
  - c_ack_i pulsed while in IDLE.
  - Required: no mN_ack_o, state stays IDLE.

Source files
------------

// File: rtl/ddr3_cache_arbiter.sv
// Three-port round-robin arbiter in front of the DDR3 line cache.
// Serialises whole 256-bit line transactions and returns a one-cycle ack with the captured line.
module ddr3_cache_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  m0_addr_i,
    input  logic [255:0] m0_data_i,
    input  logic         m0_rd_i,
    input  logic         m0_we_i,
    output logic         m0_ack_o,
    output logic [255:0] m0_data_o,
    input  logic [31:0]  m1_addr_i,
    input  logic [255:0] m1_data_i,
    input  logic         m1_rd_i,
    input  logic         m1_we_i,
    output logic         m1_ack_o,
    output logic [255:0] m1_data_o,
    input  logic [31:0]  m2_addr_i,
    input  logic [255:0] m2_data_i,
    input  logic         m2_rd_i,
    input  logic         m2_we_i,
    output logic         m2_ack_o,
    output logic [255:0] m2_data_o,
    output logic [31:0]  c_addr_o,
    output logic [255:0] c_data_o,
    output logic         c_rd_o,
    output logic         c_we_o,
    input  logic [255:0] c_data_i,
    input  logic         c_ack_i,
    output logic [1:0]   grant_o,
    output logic         busy_o
);

    localparam int unsigned NP = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 256;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_n;
    logic [1:0]      ptr, ptr_n;
    logic [1:0]      grant_n;
    logic [AW-1:0]   addr_n;
    logic [DW-1:0]   data_n;
    logic            rd_n, we_n, busy_n;
    logic [DW-1:0]   rdata, rdata_n;
    logic [NP-1:0]   ack, ack_n;

    logic [NP-1:0]   pend;
    logic [2:0]      idx;
    logic            found;
    logic [1:0]      win;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            sel_we;

    // Round-robin search starting at ptr
    always_comb begin
        pend  = {m2_rd_i | m2_we_i, m1_rd_i | m1_we_i, m0_rd_i | m0_we_i};
        found = 1'b0;
        win   = ptr;
        idx   = '0;
        for (int i = 0; i < NP; i++) begin
            idx = 3'(ptr) + 3'(i);
            if (idx >= 3'(NP)) idx = idx - 3'(NP);
            if (!found && pend[2'(idx)]) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
    end

    always_comb begin
        case (win)
            2'd0:    begin sel_addr = m0_addr_i; sel_data = m0_data_i; sel_we = m0_we_i; end
            2'd1:    begin sel_addr = m1_addr_i; sel_data = m1_data_i; sel_we = m1_we_i; end
            default: begin sel_addr = m2_addr_i; sel_data = m2_data_i; sel_we = m2_we_i; end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        grant_n = grant_o;
        addr_n  = c_addr_o;
        data_n  = c_data_o;
        rd_n    = c_rd_o;
        we_n    = c_we_o;
        rdata_n = rdata;
        ack_n   = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    addr_n  = sel_addr;
                    data_n  = sel_data;
                    we_n    = sel_we;
                    rd_n    = !sel_we;
                    grant_n = win;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (c_ack_i) begin
                    rd_n    = 1'b0;
                    we_n    = 1'b0;
                    rdata_n = c_data_i;
                    ptr_n   = (grant_o == 2'd2) ? 2'd0 : grant_o + 2'd1;
                    state_n = DONE;
                    case (grant_o)
                        2'd0:    ack_n = 3'b001;
                        2'd1:    ack_n = 3'b010;
                        default: ack_n = 3'b100;
                    endcase
                end
            end
            DONE: begin
                grant_n = 2'd3;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            grant_o  <= 2'd3;
            busy_o   <= 1'b0;
            c_addr_o <= '0;
            c_data_o <= '0;
            c_rd_o   <= 1'b0;
            c_we_o   <= 1'b0;
            rdata    <= '0;
            ack      <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            grant_o  <= grant_n;
            busy_o   <= busy_n;
            c_addr_o <= addr_n;
            c_data_o <= data_n;
            c_rd_o   <= rd_n;
            c_we_o   <= we_n;
            rdata    <= rdata_n;
            ack      <= ack_n;
        end
    end

    assign m0_ack_o  = ack[0];
    assign m1_ack_o  = ack[1];
    assign m2_ack_o  = ack[2];
    assign m0_data_o = rdata;
    assign m1_data_o = rdata;
    assign m2_data_o = rdata;

endmodule
